instruction_sequencer: RTL and testbench

- Upstream control stage for the pixel/compute datapath.
- Fetches instructions from a synchronous program ROM and presents each one on `instruction`.
- Pulses `start` to the datapath, waits for the datapath's `finished` handshake to complete, then captures `result`.
- Advances the program counter until a halt opcode, the end of the address space, a timeout or an external halt request.

---
 rtl/instruction_sequencer_if.sv | 38 +++
 rtl/instruction_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// Bus bundle between the instruction sequencer and its program ROM/datapath.
//
// Handshake: the sequencer raises `start` for one cycle only while
// `finished` is high (datapath idle). The datapath takes the request on that
// edge, drops `finished` to acknowledge, and raises it again when `result`
// is valid. `instruction` is held constant for the whole exchange.
interface instruction_sequencer_if #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int RESULT_WIDTH      = 16,
  parameter int ADDR_WIDTH        = 8
);
  logic [ADDR_WIDTH-1:0]        rom_address;
  logic [INSTRUCTION_WIDTH-1:0] rom_data;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         start;
  logic                         finished;
  logic [RESULT_WIDTH-1:0]      result;

  // Sequencer side
  modport master (
    output rom_address,
    output instruction,
    output start,
    input  rom_data,
    input  finished,
    input  result
  );

  // ROM and datapath side
  modport slave (
    input  rom_address,
    input  instruction,
    input  start,
    output rom_data,
    output finished,
    output result
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches words from a synchronous program ROM, hands
// each to the datapath with a start/finished handshake, captures the result
// and advances until a halt opcode, end of address space, timeout or an
// external halt request.
module instruction_sequencer #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int OPCODE_WIDTH      = 4,
  parameter int RESULT_WIDTH      = 16,
  parameter int ADDR_WIDTH        = 8,
  parameter int TIMEOUT           = 1023
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    halt_request,
  instruction_sequencer_if.master bus,
  output logic [RESULT_WIDTH-1:0] last_result,
  output logic [ADDR_WIDTH-1:0]   pc,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [2:0]              state_dbg
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    ISSUE     = 3'd3,
    WAIT_ACK  = 3'd4,
    WAIT_DONE = 3'd5,
    HALTED    = 3'd6
  } state_t;

  localparam logic [9:0]            TIMEOUT_CNT = 10'(TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(1);

  state_t                       state_q, state_n;
  logic [ADDR_WIDTH-1:0]        pc_q, pc_n;
  logic [ADDR_WIDTH-1:0]        rom_address_q, rom_address_n;
  logic [INSTRUCTION_WIDTH-1:0] instruction_q, instruction_n;
  logic [RESULT_WIDTH-1:0]      last_result_q, last_result_n;
  logic                         done_q, done_n;
  logic                         error_q, error_n;
  logic [9:0]                   count_q, count_n;
  logic                         halt_pending_q, halt_pending_n;
  logic                         start_c;
  logic [OPCODE_WIDTH-1:0]      opcode;
  logic                         halt_seen;

  assign opcode    = bus.rom_data[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  // A halt request seen at any point of the instruction stays armed until it
  // is honoured at the next result capture.
  assign halt_seen = halt_pending_q | halt_request;

  // State and datapath-facing registers; reset aborts without waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      pc_q           <= '0;
      rom_address_q  <= '0;
      instruction_q  <= '0;
      last_result_q  <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      count_q        <= '0;
      halt_pending_q <= 1'b0;
    end else begin
      state_q        <= state_n;
      pc_q           <= pc_n;
      rom_address_q  <= rom_address_n;
      instruction_q  <= instruction_n;
      last_result_q  <= last_result_n;
      done_q         <= done_n;
      error_q        <= error_n;
      count_q        <= count_n;
      halt_pending_q <= halt_pending_n;
    end
  end

  // Next-state and next-register logic for the fetch/issue/wait sequence.
  always_comb begin
    state_n        = state_q;
    pc_n           = pc_q;
    rom_address_n  = rom_address_q;
    instruction_n  = instruction_q;
    last_result_n  = last_result_q;
    done_n         = done_q;
    error_n        = error_q;
    count_n        = count_q;
    halt_pending_n = halt_pending_q;
    start_c        = 1'b0;

    if (state_q != HALTED) begin
      halt_pending_n = halt_pending_q | halt_request;
    end

    case (state_q)
      IDLE: begin
        if (run) begin
          state_n       = FETCH;
          pc_n          = '0;
          rom_address_n = '0;
          done_n        = 1'b0;
          error_n       = 1'b0;
        end
      end

      // The address for pc is already on the ROM; the ROM registers it on
      // this edge so the word is valid during DECODE.
      FETCH: begin
        rom_address_n = pc_q;
        state_n       = DECODE;
      end

      DECODE: begin
        instruction_n = bus.rom_data;
        if (opcode == '0) begin
          state_n        = HALTED;
          done_n         = 1'b1;
          halt_pending_n = 1'b0;
        end else begin
          state_n = ISSUE;
        end
      end

      // start is combinational so it can only appear here and only while
      // the datapath reports idle.
      ISSUE: begin
        if (bus.finished) begin
          start_c = 1'b1;
          count_n = '0;
          state_n = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        if (!bus.finished) begin
          count_n = '0;
          state_n = WAIT_DONE;
        end else if (count_q == TIMEOUT_CNT) begin
          state_n        = HALTED;
          error_n        = 1'b1;
          halt_pending_n = 1'b0;
        end else begin
          count_n = count_q + 10'd1;
        end
      end

      WAIT_DONE: begin
        if (bus.finished) begin
          last_result_n = bus.result;
          if (halt_seen || (pc_q == '1)) begin
            state_n        = HALTED;
            done_n         = 1'b1;
            halt_pending_n = 1'b0;
          end else begin
            pc_n          = pc_q + PC_STEP;
            rom_address_n = pc_q + PC_STEP;
            state_n       = FETCH;
          end
        end else if (count_q == TIMEOUT_CNT) begin
          state_n        = HALTED;
          error_n        = 1'b1;
          halt_pending_n = 1'b0;
        end else begin
          count_n = count_q + 10'd1;
        end
      end

      // Leave only once run drops, so a restart needs a fresh rising level.
      HALTED: begin
        if (!run) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.rom_address = rom_address_q;
  assign bus.instruction = instruction_q;
  assign bus.start       = start_c;
  assign last_result     = last_result_q;
  assign pc              = pc_q;
  assign done            = done_q;
  assign error           = error_q;
  assign busy            = (state_q != IDLE) && (state_q != HALTED);
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: an 8-bit-address instance for the
// main scenarios and a 2-bit-address instance for end-of-space stopping.
module tb_instruction_sequencer;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_HALTED    = 3'd6;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // ---------------- instance A (ADDR_WIDTH = 8) ----------------
  logic        run = 1'b0;
  logic        halt_request = 1'b0;
  logic [15:0] last_result;
  logic [7:0]  pc;
  logic        busy, done, error;
  logic [2:0]  state_dbg;
  logic [15:0] rom [256];

  instruction_sequencer_if #(.INSTRUCTION_WIDTH(16), .RESULT_WIDTH(16), .ADDR_WIDTH(8)) bus ();

  instruction_sequencer #(
    .INSTRUCTION_WIDTH(16), .OPCODE_WIDTH(4), .RESULT_WIDTH(16), .ADDR_WIDTH(8), .TIMEOUT(1023)
  ) u_dut (
    .clock(clock), .reset(reset), .run(run), .halt_request(halt_request), .bus(bus),
    .last_result(last_result), .pc(pc), .busy(busy), .done(done), .error(error),
    .state_dbg(state_dbg)
  );

  // ---------------- instance B (ADDR_WIDTH = 2) ----------------
  logic        run2 = 1'b0;
  logic        halt2 = 1'b0;
  logic [15:0] last_result2;
  logic [1:0]  pc2;
  logic        busy2, done2, error2;
  logic [2:0]  state_dbg2;
  logic [15:0] rom2 [4];

  instruction_sequencer_if #(.INSTRUCTION_WIDTH(16), .RESULT_WIDTH(16), .ADDR_WIDTH(2)) bus2 ();

  instruction_sequencer #(
    .INSTRUCTION_WIDTH(16), .OPCODE_WIDTH(4), .RESULT_WIDTH(16), .ADDR_WIDTH(2), .TIMEOUT(1023)
  ) u_dut2 (
    .clock(clock), .reset(reset), .run(run2), .halt_request(halt2), .bus(bus2),
    .last_result(last_result2), .pc(pc2), .busy(busy2), .done(done2), .error(error2),
    .state_dbg(state_dbg2)
  );

  // ---------------- ROM models (one-cycle synchronous read) ----------------
  always @(posedge clock) bus.rom_data  <= rom[bus.rom_address];
  always @(posedge clock) bus2.rom_data <= rom2[bus2.rom_address];

  // ---------------- datapath model A ----------------
  // Takes start, drops finished one cycle later, raises it two cycles after
  // that with result = 0x00AB + instruction[7:0]. no_ack freezes it busy-idle.
  logic        no_ack = 1'b0;
  logic [1:0]  ph;
  logic [15:0] held;
  int          start_count = 0;
  int          start_bad   = 0;
  int          stab_err    = 0;

  always @(posedge clock) begin
    if (bus.start && (!bus.finished || state_dbg != 3'd3)) start_bad <= start_bad + 1;
    if (bus.start) start_count <= start_count + 1;
    if (ph != 2'd0 && bus.instruction !== held) stab_err <= stab_err + 1;
    if (reset) begin
      ph           <= 2'd0;
      bus.finished <= 1'b1;
      bus.result   <= 16'h0;
    end else begin
      case (ph)
        2'd0: if (bus.start) begin ph <= 2'd1; held <= bus.instruction; end
        2'd1: if (!no_ack) begin bus.finished <= 1'b0; ph <= 2'd2; end
        2'd2: ph <= 2'd3;
        default: begin
          bus.finished <= 1'b1;
          bus.result   <= 16'h00AB + {8'h00, held[7:0]};
          ph           <= 2'd0;
        end
      endcase
    end
  end

  // ---------------- datapath model B ----------------
  logic [1:0]  ph2;
  logic [15:0] held2;
  int          start_count2 = 0;

  always @(posedge clock) begin
    if (bus2.start) start_count2 <= start_count2 + 1;
    if (reset) begin
      ph2           <= 2'd0;
      bus2.finished <= 1'b1;
      bus2.result   <= 16'h0;
    end else begin
      case (ph2)
        2'd0: if (bus2.start) begin ph2 <= 2'd1; held2 <= bus2.instruction; end
        2'd1: begin bus2.finished <= 1'b0; ph2 <= 2'd2; end
        2'd2: ph2 <= 2'd3;
        default: begin
          bus2.finished <= 1'b1;
          bus2.result   <= 16'h00AB + {8'h00, held2[7:0]};
          ph2           <= 2'd0;
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input int bound, input string tag);
    int n;
    n = 0;
    while (state_dbg !== st && n < bound) begin
      @(negedge clock);
      n++;
    end
    check(tag, {29'd0, state_dbg}, {29'd0, st});
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic load_seq3;
    rom[0] = 16'h1001; rom[1] = 16'h1002; rom[2] = 16'h1003; rom[3] = 16'h0000;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int sc0;
    int n;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom2[0] = 16'h2001; rom2[1] = 16'h2002; rom2[2] = 16'h2003; rom2[3] = 16'h2004;

    // reset state
    wait_cycles(3);
    reset = 1'b0;
    @(negedge clock);
    check("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_rom_addr", {24'd0, bus.rom_address}, 32'd0);
    check("rst_instr", {16'd0, bus.instruction}, 32'd0);
    check("rst_start", {31'd0, bus.start}, 32'd0);
    check("rst_last", {16'd0, last_result}, 32'd0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);

    // single instruction then halt opcode
    rom[0] = 16'h1000; rom[1] = 16'h0000;
    sc0 = start_count;
    run = 1'b1;
    @(negedge clock);
    check("t1_fetch", {29'd0, state_dbg}, {29'd0, S_FETCH});
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_state(S_HALTED, 100, "t1_halted");
    check("t1_starts", start_count - sc0, 32'd1);
    check("t1_last", {16'd0, last_result}, 32'h00AB);
    check("t1_pc", {24'd0, pc}, 32'd1);
    check("t1_flags", {29'd0, busy, done, error}, 32'b010);
    check("t1_instr", {16'd0, bus.instruction}, 32'h0000);
    wait_cycles(5);
    check("t1_no_restart", {29'd0, state_dbg}, {29'd0, S_HALTED});

    // three instructions, then halt opcode
    run = 1'b0;
    wait_cycles(2);
    check("t2_idle", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check("t2_done_kept", {31'd0, done}, 32'd1);
    load_seq3();
    sc0 = start_count;
    run = 1'b1;
    @(negedge clock);
    check("t2_done_clr", {31'd0, done}, 32'd0);
    wait_state(S_HALTED, 200, "t2_halted");
    check("t2_starts", start_count - sc0, 32'd3);
    check("t2_pc", {24'd0, pc}, 32'd3);
    check("t2_last", {16'd0, last_result}, 32'h00AE);
    check("t2_flags", {29'd0, busy, done, error}, 32'b010);
    check("t2_stable", stab_err, 32'd0);
    check("t2_start_rules", start_bad, 32'd0);

    // datapath never acknowledges: timeout in WAIT_ACK
    run = 1'b0;
    wait_cycles(2);
    no_ack = 1'b1;
    rom[0] = 16'h1000;
    run = 1'b1;
    wait_state(S_WAIT_ACK, 20, "t3_wait_ack");
    n = 0;
    while (state_dbg == S_WAIT_ACK && n < 1200) begin
      @(negedge clock);
      n++;
    end
    check("t3_timeout_len", {31'd0, (n >= 1023 && n <= 1024)}, 32'd1);
    check("t3_state", {29'd0, state_dbg}, {29'd0, S_HALTED});
    check("t3_flags", {29'd0, busy, done, error}, 32'b001);
    check("t3_last_kept", {16'd0, last_result}, 32'h00AE);

    // reset in WAIT_DONE aborts, then a clean restart from address 0
    reset = 1'b1;
    run = 1'b0;
    no_ack = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    load_seq3();
    run = 1'b1;
    wait_state(S_WAIT_DONE, 50, "t4_wait_done");
    reset = 1'b1;
    run = 1'b0;
    @(negedge clock);
    check("t4_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
    check("t4_start", {31'd0, bus.start}, 32'd0);
    check("t4_pc", {24'd0, pc}, 32'd0);
    check("t4_instr", {16'd0, bus.instruction}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    sc0 = start_count;
    run = 1'b1;
    wait_state(S_HALTED, 200, "t4_halted");
    check("t4_starts", start_count - sc0, 32'd3);
    check("t4_pc_end", {24'd0, pc}, 32'd3);
    check("t4_done", {29'd0, busy, done, error}, 32'b010);

    // halt_request during WAIT_DONE of ROM[0]
    run = 1'b0;
    wait_cycles(2);
    sc0 = start_count;
    run = 1'b1;
    wait_state(S_WAIT_DONE, 50, "t5_wait_done");
    halt_request = 1'b1;
    wait_state(S_HALTED, 50, "t5_halted");
    check("t5_pc", {24'd0, pc}, 32'd0);
    check("t5_flags", {29'd0, busy, done, error}, 32'b010);
    check("t5_last", {16'd0, last_result}, 32'h00AC);
    wait_cycles(10);
    check("t5_no_fetch", start_count - sc0, 32'd1);
    check("t5_still_halted", {29'd0, state_dbg}, {29'd0, S_HALTED});
    halt_request = 1'b0;
    run = 1'b0;

    // 2-bit address space, all words non-zero: stop at pc=3, no wrap
    sc0 = start_count2;
    run2 = 1'b1;
    n = 0;
    while (state_dbg2 !== S_HALTED && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("t6_halted", {29'd0, state_dbg2}, {29'd0, S_HALTED});
    check("t6_starts", start_count2 - sc0, 32'd4);
    check("t6_pc", {30'd0, pc2}, 32'd3);
    check("t6_flags", {29'd0, busy2, done2, error2}, 32'b010);
    check("t6_last", {16'd0, last_result2}, 32'h00AF);
    wait_cycles(10);
    check("t6_no_wrap", {30'd0, pc2}, 32'd3);
    check("t6_no_more", start_count2 - sc0, 32'd4);
    run2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
